regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: A (ALU result path) and B (load / memory path).
- Round-robin arbitration with valid/ready handshakes.
- Registered write stage that decodes the winner's address into one per-register enable bit for the register flip-flops.
- Writes to x0 are accepted and discarded; the zero register never receives an enable.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two.
- ADDR_W, 5, register address width; must equal log2(NREGS).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_valid  input  1  requester A presents a write.
- a_ready  output  1  A's write is accepted this cycle.
- a_addr  input  ADDR_W  A destination register.
- a_data  input  WIDTH  A write data.
- b_valid  input  1  requester B presents a write.
- b_ready  output  1  B's write is accepted this cycle.
- b_addr  input  ADDR_W  B destination register.
- b_data  input  WIDTH  B write data.
- wr_hold  input  1  freeze: no new grants while high.
- wr_en  output  NREGS  one-hot per-register write enable; bit 0 is always 0.
- wr_data  output  WIDTH  data for the enabled register.
- last_grant  output  1  0 = A won the most recent grant, 1 = B won.

Behaviour:
- Reset (reset low, asynchronous):
  - wr_en = 0, wr_data = 0, last_grant = 1 (so A has first priority), state = IDLE.
  - a_ready and b_ready are forced to 0 while reset is low.
- State machine:
  - IDLE: no write is registered.
  - WRITE: exactly one wr_en bit may be high.
  - HOLD: wr_hold is asserted.
  - Transitions are evaluated every cycle from the current inputs:
    - wr_hold = 1 → HOLD.
    - wr_hold = 0 and a grant is issued → WRITE.
    - Otherwise → IDLE.
- Grant (combinational):
  - No grant when wr_hold = 1.
  - Only one requester valid → that one is granted.
  - Both valid → the requester other than last_grant is granted.
  - a_ready and b_ready are the grant signals; at most one is high per cycle.
  - A requester holds addr/data stable while valid and not ready.
- Write stage (registered, latency 1):
  - The cycle after a grant, wr_data = granted data and wr_en = one-hot(granted addr).
  - If the granted addr = 0, wr_en = 0, but the grant still counts and last_grant still updates.
  - With no grant in a cycle, the next wr_en = 0 and wr_data holds its previous value.
  - wr_en is never held high for more than one cycle per grant.
- last_grant updates only on a cycle with a grant.
- HOLD:
  - Both ready outputs are 0 and last_grant is frozen.
  - Any write granted in the cycle before HOLD still completes in the first HOLD cycle.
  - On leaving HOLD, arbitration resumes with the frozen priority.
- Both requesters targeting the same address: they are serialised in grant order, so the later grant's data is what remains in the register.
- Reset asserted mid-operation: the registered write is dropped and wr_en clears immediately.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate A, B, A, B.

Optional Feature:
- Macro: REGFILE_ARB_CONFLICT_CNT_EN.
- When defined:
  - Adds output conflict_cnt [15:0], reset to 0.
  - Increments by 1 on every cycle where a_valid and b_valid are both high and wr_hold is low.
  - Saturates at 16'hFFFF; does not wrap.
- When undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Reset low, then released with no requests → wr_en = 0, wr_data = 0, last_grant = 1, a_ready = b_ready = 0.
- a_valid = 1, a_addr = 5, a_data = 32'hDEADBEEF for one cycle → a_ready = 1 that cycle; next cycle wr_en = 32'h0000_0020, wr_data = 32'hDEADBEEF; the following cycle wr_en = 0.
- A and B both continuously valid for 4 cycles, A addr 3, B addr 7 → grants A, B, A, B; wr_en alternates 32'h8 and 32'h80 starting one cycle later.
- b_valid = 1, b_addr = 0, b_data = 32'h1234 → b_ready = 1; next cycle wr_en = 0; last_grant = 1.
- Both valid with wr_hold = 1 for 3 cycles, then released → no readies and wr_en = 0 during hold; the first grant after release goes to the requester opposite the pre-hold last_grant.
- With REGFILE_ARB_CONFLICT_CNT_EN defined: 5 cycles with both valid, then reset pulsed low mid-sequence → conflict_cnt = 5 before the reset, 0 immediately on reset; any pending wr_en clears without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-back arbiter: two requesters share one register file write port.
// Optional saturating conflict counter enabled by REGFILE_ARB_CONFLICT_CNT_EN.
module regfile_wr_arbiter #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_data,
  input  logic              wr_hold,
  output logic [NREGS-1:0]  wr_en,
  output logic [WIDTH-1:0]  wr_data,
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
  output logic [15:0]       conflict_cnt,
`endif
  output logic              last_grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NREGS-1:0]   wr_en_q, wr_en_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_a, grant_b;
  logic [ADDR_W-1:0]  sel_addr;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!wr_hold) begin
      if (a_valid && b_valid) begin
        grant_a = last_grant_q;
        grant_b = ~last_grant_q;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  always_comb begin
    state_d      = IDLE;
    wr_en_d      = '0;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    sel_addr     = '0;

    if (wr_hold)
      state_d = HOLD;
    else if (grant_a || grant_b)
      state_d = WRITE;

    if (grant_a) begin
      sel_addr     = a_addr;
      wr_data_d    = a_data;
      last_grant_d = 1'b0;
    end else if (grant_b) begin
      sel_addr     = b_addr;
      wr_data_d    = b_data;
      last_grant_d = 1'b1;
    end

    // x0 writes are accepted but never raise an enable.
    if ((grant_a || grant_b) && (sel_addr != '0))
      wr_en_d = {{(NREGS-1){1'b0}}, 1'b1} << sel_addr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_en_q      <= '0;
      wr_data_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef REGFILE_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (a_valid && b_valid && !wr_hold && (conflict_cnt_q != '1))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      conflict_cnt_q <= '0;
    else
      conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

  assign a_ready    = grant_a & reset;
  assign b_ready    = grant_b & reset;
  // A registered enable only ever exists in WRITE; the state gate keeps the two consistent.
  assign wr_en      = (state_q == WRITE) ? wr_en_q : '0;
  assign wr_data    = wr_data_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed vector table, random traffic
// against a behavioural model, and a mid-operation reset sequence.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, wr_hold;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic [31:0] wr_en;
  logic [31:0] wr_data;
  logic        last_grant;
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.WIDTH(32), .NREGS(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_hold(wr_hold), .wr_en(wr_en), .wr_data(wr_data),
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .last_grant(last_grant)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: who wins, what lands in the register file next cycle.
  logic [31:0] m_wr_en, m_wr_data;
  logic        m_last;
  int          m_cnt;

  function automatic int winner(input logic av, input logic bv, input logic hold, input logic last);
    if (hold) return 0;
    if (av && bv) return last ? 1 : 2;
    if (av) return 1;
    if (bv) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_wr_en = 0; m_wr_data = 0; m_last = 1'b1; m_cnt = 0;
    end else begin
      int w;
      w = winner(a_valid, b_valid, wr_hold, m_last);
      if (a_valid && b_valid && !wr_hold && m_cnt < 65535) m_cnt++;
      m_wr_en = 0;
      if (w == 1) begin
        m_wr_data = a_data; m_last = 1'b0;
        if (a_addr != 0) m_wr_en = 32'd1 << a_addr;
      end else if (w == 2) begin
        m_wr_data = b_data; m_last = 1'b1;
        if (b_addr != 0) m_wr_en = 32'd1 << b_addr;
      end
    end
  end

  typedef struct {
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        bv; logic [4:0] ba; logic [31:0] bd;
    logic        hold;
    logic        ea, eb;
    logic [31:0] een, edata;
    logic        elast;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic hold, input logic ea, input logic eb,
                              input logic [31:0] een, input logic [31:0] edata, input logic elast);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd; v.hold = hold;
    v.ea = ea; v.eb = eb; v.een = een; v.edata = edata; v.elast = elast;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic hold);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    wr_hold = hold;
  endtask

  initial begin
    logic pa_ready, pb_ready;
    // Columns: A(valid,addr,data) B(valid,addr,data) hold | a_ready b_ready wr_en wr_data last_grant
    tbl[0]  = mk(0,0,0,                 0,0,0,                 0, 0,0, 32'h0,     32'h0,         1);
    tbl[1]  = mk(1,5,32'hDEADBEEF,      0,0,0,                 0, 1,0, 32'h0,     32'h0,         1);
    tbl[2]  = mk(0,0,0,                 0,0,0,                 0, 0,0, 32'h20,    32'hDEADBEEF,  0);
    tbl[3]  = mk(0,0,0,                 0,0,0,                 0, 0,0, 32'h0,     32'hDEADBEEF,  0);
    tbl[4]  = mk(0,0,0,                 1,0,32'h1234,          0, 0,1, 32'h0,     32'hDEADBEEF,  0);
    tbl[5]  = mk(1,3,32'hAAAA0003,      1,7,32'hBBBB0007,      0, 1,0, 32'h0,     32'h1234,      1);
    tbl[6]  = mk(1,3,32'hAAAA0003,      1,7,32'hBBBB0007,      0, 0,1, 32'h8,     32'hAAAA0003,  0);
    tbl[7]  = mk(1,3,32'hAAAA0003,      1,7,32'hBBBB0007,      0, 1,0, 32'h80,    32'hBBBB0007,  1);
    tbl[8]  = mk(1,3,32'hAAAA0003,      1,7,32'hBBBB0007,      0, 0,1, 32'h8,     32'hAAAA0003,  0);
    tbl[9]  = mk(1,3,32'hAAAA0003,      1,7,32'hBBBB0007,      1, 0,0, 32'h80,    32'hBBBB0007,  1);
    tbl[10] = mk(1,3,32'hAAAA0003,      1,7,32'hBBBB0007,      1, 0,0, 32'h0,     32'hBBBB0007,  1);
    tbl[11] = mk(1,3,32'hAAAA0003,      1,7,32'hBBBB0007,      1, 0,0, 32'h0,     32'hBBBB0007,  1);
    tbl[12] = mk(1,3,32'hAAAA0003,      1,7,32'hBBBB0007,      0, 1,0, 32'h0,     32'hBBBB0007,  1);
    tbl[13] = mk(0,0,0,                 0,0,0,                 0, 0,0, 32'h8,     32'hAAAA0003,  0);
    tbl[14] = mk(1,9,32'h11,            1,9,32'h22,            0, 0,1, 32'h0,     32'hAAAA0003,  0);
    tbl[15] = mk(1,9,32'h11,            1,9,32'h22,            0, 1,0, 32'h200,   32'h22,        1);
    tbl[16] = mk(0,0,0,                 0,0,0,                 0, 0,0, 32'h200,   32'h11,        0);
    tbl[17] = mk(0,0,0,                 0,0,0,                 0, 0,0, 32'h0,     32'h11,        0);

    reset = 1'b0;
    drive(1, 5, 32'hFFFF_FFFF, 1, 6, 32'hEEEE_EEEE, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_last_grant", last_grant, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table: drive after a rising edge, check at the following falling edge.
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd, tbl[i].hold);
      @(negedge clk);
      check($sformatf("tbl%0d_a_ready", i), a_ready, tbl[i].ea);
      check($sformatf("tbl%0d_b_ready", i), b_ready, tbl[i].eb);
      check($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].een);
      check($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].edata);
      check($sformatf("tbl%0d_last", i), last_grant, tbl[i].elast);
    end

    // Random traffic; a requester left waiting keeps its request unchanged.
    pa_ready = 1'b0; pb_ready = 1'b0;
    for (int i = 0; i < 400; i++) begin
      int w;
      @(posedge clk); #1;
      if (!(a_valid && !pa_ready)) begin
        a_valid = ($urandom_range(0, 9) < 6);
        a_addr  = 5'($urandom_range(0, 31));
        a_data  = $urandom;
      end
      if (!(b_valid && !pb_ready)) begin
        b_valid = ($urandom_range(0, 9) < 6);
        b_addr  = 5'($urandom_range(0, 31));
        b_data  = $urandom;
      end
      wr_hold = ($urandom_range(0, 9) < 2);
      @(negedge clk);
      w = winner(a_valid, b_valid, wr_hold, m_last);
      check("rnd_a_ready", a_ready, (w == 1));
      check("rnd_b_ready", b_ready, (w == 2));
      check("rnd_wr_en", wr_en, m_wr_en);
      check("rnd_wr_data", wr_data, m_wr_data);
      check("rnd_last", last_grant, m_last);
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
      check("rnd_conflict_cnt", conflict_cnt, m_cnt[15:0]);
`endif
      pa_ready = a_ready;
      pb_ready = b_ready;
    end

    // Fresh reset, five contended cycles, then reset lands with a write pending.
    @(negedge clk);
    reset = 1'b0;
    drive(1, 3, 32'hC0DE0003, 1, 7, 32'hC0DE0007, 0);
    #2;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("pend_wr_en", wr_en, 32'h8);
    check("pend_wr_data", wr_data, 32'hC0DE0003);
    check("pend_last", last_grant, 0);
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    check("cnt_before_reset", conflict_cnt, 16'd5);
`endif
    #2;
    reset = 1'b0;
    a_valid = 1'b1;
    #1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_last", last_grant, 1);
    check("mid_rst_a_ready", a_ready, 0);
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    check("cnt_after_reset", conflict_cnt, 16'd0);
`endif
    @(negedge clk);
    a_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 12, 32'h5A5A, 0);
    @(negedge clk);
    check("post_rst_b_ready", b_ready, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("post_rst_wr_en", wr_en, 32'h1000);
    check("post_rst_wr_data", wr_data, 32'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
